// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and constants for the TDC hit collector
package tdc_pkg;

  localparam int HIT_TDC_W = 12;
  localparam int HIT_BC_W  = 7;
  localparam int DROP_W    = 4;

  typedef struct packed {
    logic [HIT_TDC_W-1:0] tdc;
    logic [HIT_BC_W-1:0]  bc;
  } hit_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/tdc_hit_fifo.sv
// rtl/tdc_hit_fifo.sv - per-channel synchronous FIFO with same-cycle read/write
module tdc_hit_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          do_wr;
  logic          do_rd;

  // A write into a full FIFO is still taken when the head leaves on the same edge.
  assign do_rd = rd_en_i & (count_q != '0);
  assign do_wr = wr_en_i & ((count_q != FULL_CNT) | do_rd);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);

endmodule

// File: rtl/tdc_hit_collector.sv
// rtl/tdc_hit_collector.sv - edge-detected TDC hit capture, per-channel FIFOs, round-robin output
module tdc_hit_collector
  import tdc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int TDC_W = HIT_TDC_W,
  parameter int BC_W  = HIT_BC_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk300,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_CH-1:0]          ch_rdy,
  input  logic [N_CH*TDC_W-1:0]    ch_tdc,
  input  logic [BC_W-1:0]          bc_time,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [$clog2(N_CH)-1:0]  out_ch,
  output logic [TDC_W-1:0]         out_tdc,
  output logic [BC_W-1:0]          out_bc,
  output logic [N_CH-1:0]          ch_full,
  output logic [N_CH*DROP_W-1:0]   drop_cnt
);

  localparam int CH_W = $clog2(N_CH);
  localparam int HW   = TDC_W + BC_W;

  logic [N_CH-1:0]  rdy_prev_q;
  logic [N_CH-1:0]  hit;
  logic [N_CH-1:0]  fifo_empty;
  logic [N_CH-1:0]  fifo_full;
  logic [N_CH-1:0]  pop;
  logic [HW-1:0]    head [N_CH];

  out_state_e       state_q, state_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CH_W-1:0]  gnt;
  logic             any_ne;
  logic             load;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [TDC_W-1:0] out_tdc_q, out_tdc_d;
  logic [BC_W-1:0]  out_bc_q, out_bc_d;

  assign hit = ch_rdy & ~rdy_prev_q & {N_CH{enable}};

  always_ff @(posedge clk300) begin
    if (reset) begin
      rdy_prev_q <= '0;
    end else begin
      rdy_prev_q <= ch_rdy;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DROP_W-1:0] drop_q;

    tdc_hit_fifo #(
      .W     (HW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i     (clk300),
      .reset_i   (reset),
      .wr_en_i   (hit[c]),
      .wr_data_i ({ch_tdc[c*TDC_W +: TDC_W], bc_time}),
      .rd_en_i   (pop[c]),
      .rd_data_o (head[c]),
      .empty_o   (fifo_empty[c]),
      .full_o    (fifo_full[c])
    );

    always_ff @(posedge clk300) begin
      if (reset) begin
        drop_q <= '0;
      end else if (hit[c] && fifo_full[c] && !pop[c] && drop_q != '1) begin
        drop_q <= drop_q + DROP_W'(1);
      end
    end

    assign drop_cnt[c*DROP_W +: DROP_W] = drop_q;
  end

  // Search starts one past the last grant, so last_q = N_CH-1 favours channel 0.
  always_comb begin
    int idx;
    idx    = 0;
    gnt    = last_q;
    any_ne = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!any_ne && !fifo_empty[idx]) begin
        any_ne = 1'b1;
        gnt    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    pop       = '0;
    load      = 1'b0;
    out_ch_d  = out_ch_q;
    out_tdc_d = out_tdc_q;
    out_bc_d  = out_bc_q;
    case (state_q)
      OUT_EMPTY: begin
        if (any_ne) begin
          load = 1'b1;
        end
      end
      OUT_FULL: begin
        if (out_ready) begin
          if (any_ne) begin
            load = 1'b1;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
    if (load) begin
      state_d   = OUT_FULL;
      pop[gnt]  = 1'b1;
      last_d    = gnt;
      out_ch_d  = gnt;
      out_tdc_d = head[gnt][HW-1 -: TDC_W];
      out_bc_d  = head[gnt][BC_W-1:0];
    end
  end

  always_ff @(posedge clk300) begin
    if (reset) begin
      state_q   <= OUT_EMPTY;
      last_q    <= CH_W'(N_CH - 1);
      out_ch_q  <= '0;
      out_tdc_q <= '0;
      out_bc_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      out_ch_q  <= out_ch_d;
      out_tdc_q <= out_tdc_d;
      out_bc_q  <= out_bc_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_ch    = out_ch_q;
  assign out_tdc   = out_tdc_q;
  assign out_bc    = out_bc_q;
  assign ch_full   = fifo_full;

endmodule

// File: doc/tdc_hit_collector.md
TDC_HIT_COLLECTOR -- requirements
Module: tdc_hit_collector

Interface
REQ-001 Parameter N_CH, default 4: number of TDC channels, range 2..16.
REQ-002 Parameter TDC_W, default 12: width of a channel fine-time word.
REQ-003 Parameter BC_W, default 7: width of the bunch-crossing time stamp.
REQ-004 Parameter DEPTH, default 4: per-channel FIFO depth, power of two, at least 2.
REQ-005 Port clk300, input, 1 bit: the single clock; every register is updated on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port enable, input, 1 bit: when high, hit capture is allowed; when low, new hits are ignored.
REQ-008 Port ch_rdy, input, N_CH bits: per-channel TDC ready level.
REQ-009 Port ch_tdc, input, N_CH x TDC_W bits: per-channel fine-time word, valid while ch_rdy is high.
REQ-010 Port bc_time, input, BC_W bits: free-running bunch-crossing counter.
REQ-011 Port out_ready, input, 1 bit: downstream accept signal.
REQ-012 Port out_valid, output, 1 bit: the output hit is valid.
REQ-013 Port out_ch, output, clog2(N_CH) bits: channel index of the output hit.
REQ-014 Port out_tdc, output, TDC_W bits: fine time of the output hit.
REQ-015 Port out_bc, output, BC_W bits: bc_time captured with the hit.
REQ-016 Port ch_full, output, N_CH bits: per-channel FIFO full flag, registered.
REQ-017 Port drop_cnt, output, N_CH x 4 bits: per-channel count of dropped hits.

Function
REQ-018 A hit SHALL be detected on channel c at the edge where ch_rdy[c]=1, the registered previous ch_rdy[c]=0, and enable=1; a level held high for several cycles SHALL count as one hit.
REQ-019 At the detecting edge, the entry {ch_tdc[c], bc_time} SHALL be written into FIFO c; bc_time wraps naturally and no unwrapping is performed.
REQ-020 A hit arriving while FIFO c is full with no same-cycle read SHALL be dropped, and drop_cnt[c] SHALL increment, saturating at 15.
REQ-021 When FIFO c is full and is read in the same cycle that a hit is detected on it, the hit SHALL be accepted.
REQ-022 The output stage SHALL be a two-state FSM:
- EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY->FULL when any FIFO is non-empty.
- FULL->EMPTY when out_ready=1 and all FIFOs are empty after the pop.
- FULL->FULL (reload) when out_ready=1 and a FIFO is non-empty.
REQ-023 Loading the output register SHALL pop exactly one entry; out_ch, out_tdc and out_bc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Channel selection SHALL be round-robin over non-empty FIFOs, starting from the channel after the last granted one; the pointer SHALL advance only on a load.
REQ-025 Latency SHALL be as follows:
- A hit detected at edge k on an idle block SHALL give out_valid=1 after edge k+1.
- With out_ready held high, one hit SHALL be delivered per cycle.
REQ-026 Simultaneous hits on several channels in one cycle SHALL all be stored, with no loss while FIFOs have space.
REQ-027 ch_full[c] SHALL reflect the FIFO occupancy after the current edge's write and read.
REQ-028 Deasserting enable SHALL NOT discard stored hits; draining SHALL continue.

Reset
REQ-029 While reset=1, at each edge, the block SHALL:
- empty all FIFOs;
- set out_valid=0, out_ch=0, out_tdc=0, out_bc=0;
- set ch_full=0 and drop_cnt=0;
- set the round-robin pointer so that channel 0 has highest priority;
- clear the previous-ch_rdy registers to 0.
REQ-030 Reset asserted mid-transfer SHALL discard the held output word; no hit SHALL be emitted during the first cycle after reset deasserts.
REQ-031 A ch_rdy level already high when reset deasserts SHALL be detected as a hit on the first edge with enable=1.

Structure
REQ-032 Shared package tdc_pkg SHALL hold:
- the hit_t struct {tdc, bc};
- the output-FSM state enum;
- the drop-counter width constant (4).
REQ-033 Sub-module tdc_hit_fifo (one instance per channel via generate) SHALL provide synchronous FIFO storage with write, read, empty, full and simultaneous read/write.
REQ-034 The arbiter and output FSM SHALL reside in tdc_hit_collector.

Verification (N_CH=4, DEPTH=4, TDC_W=12, BC_W=7)
REQ-035 Single hit: ch_rdy[2] rises with ch_tdc[2]=0x5A3 and bc_time=17, out_ready=1 -> out_valid for one cycle, two edges later, with out_ch=2, out_tdc=0x5A3, out_bc=17.
REQ-036 Simultaneous hits: ch_rdy[0..3] rise together, out_ready=1 -> four outputs on consecutive cycles in order 0,1,2,3; a second burst after grant 3 is delivered starting at channel 0.
REQ-037 Backpressure: out_ready=0 for 10 cycles with a held word -> out_* stable for all 10 cycles, no pop.
REQ-038 Overflow: six hits on channel 1 with out_ready=0 -> 4 stored, ch_full[1]=1, drop_cnt[1]=1 (the held word uses one entry); 20 further drops -> drop_cnt[1]=15.
REQ-039 Level versus edge, and enable: ch_rdy[3] held high for 8 cycles -> exactly one hit; a rise with enable=0 -> no hit.
REQ-040 Reset mid-operation: reset asserted for one cycle with 3 stored hits and out_valid=1 -> out_valid=0, drop_cnt=0 and no stale hit emitted afterwards.
